// File: rtl/majority_voter_seq_if.sv
// Bus bundle for the registered N-channel majority voter: redundant input
// samples in, voted word plus per-channel fault status out.
interface majority_voter_seq_if #(
    parameter int N = 3,
    parameter int W = 1
);
    logic [N*W-1:0] IN_DATA;
    logic           IN_VALID;
    logic           CLR_FAULT;
    logic [W-1:0]   F;
    logic           F_VALID;
    logic [N-1:0]   DISAGREE;
    logic [N-1:0]   ISOLATED;
    logic           TIE;
    logic           NO_QUORUM;

    // Producer / consumer side of the voter
    modport master (
        output IN_DATA, IN_VALID, CLR_FAULT,
        input  F, F_VALID, DISAGREE, ISOLATED, TIE, NO_QUORUM
    );

    // Voter side
    modport slave (
        input  IN_DATA, IN_VALID, CLR_FAULT,
        output F, F_VALID, DISAGREE, ISOLATED, TIE, NO_QUORUM
    );
endinterface

// File: rtl/majority_voter_seq.sv
// Registered N-channel, W-bit majority voter. Each output bit is the strict
// majority of that bit over the non-isolated channels; ties resolve to 0 and
// raise TIE. A channel that disagrees with the vote on FAULT_LIMIT consecutive
// valid samples is isolated until reset or a CLR_FAULT pulse.
module majority_voter_seq #(
    parameter int N           = 3,
    parameter int W           = 1,
    parameter int FAULT_LIMIT = 4
) (
    input logic CLK,
    input logic RST,
    majority_voter_seq_if.slave bus
);

    localparam int CW = $clog2(FAULT_LIMIT + 1);
    localparam int PW = $clog2(N + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FAULT_LIMIT);

    // Registered outputs and sticky isolation state
    logic [W-1:0] fReg;
    logic         fValidReg;
    logic [N-1:0] disagreeReg;
    logic [N-1:0] isolatedReg;
    logic [N-1:0] isolatedNext;
    logic         tieReg;
    logic         noQuorumReg;

    // Combinational vote over the pre-edge active set
    logic [PW-1:0] actCount;
    logic          quorum;
    logic [W-1:0]  voteWord;
    logic [W-1:0]  tieBits;
    logic [N-1:0]  disagreeVec;

    // Count channels still taking part in the vote
    always_comb begin
        actCount = '0;
        for (int c = 0; c < N; c++) begin
            if (!isolatedReg[c]) begin
                actCount = actCount + PW'(1);
            end
        end
    end

    assign quorum = (actCount != '0);

    genvar gi;

    // Per-bit popcount over active channels; doubling the count keeps the
    // majority/tie test exact for both odd and even active counts
    generate
        for (gi = 0; gi < W; gi++) begin : bitVote
            logic [PW-1:0] onesCount;

            // Active channels voting 1 on this bit
            always_comb begin
                onesCount = '0;
                for (int c = 0; c < N; c++) begin
                    if (!isolatedReg[c] && bus.IN_DATA[c*W + gi]) begin
                        onesCount = onesCount + PW'(1);
                    end
                end
            end

            assign voteWord[gi] = {onesCount, 1'b0} >  {1'b0, actCount};
            assign tieBits[gi]  = {onesCount, 1'b0} == {1'b0, actCount};
        end
    endgenerate

    // Per-channel disagreement flag, fault counter and isolation decision.
    // Disagreement is reported for isolated channels too so recovery is
    // visible, but only active channels move their counters.
    generate
        for (gi = 0; gi < N; gi++) begin : chanState
            logic [W-1:0]  chWord;
            logic [CW-1:0] cntReg;
            logic [CW-1:0] cntNext;
            logic          isoBit;

            assign chWord          = bus.IN_DATA[gi*W +: W];
            assign disagreeVec[gi] = quorum && (chWord != voteWord);

            // Counter and isolation next-state; a clear overrides any update
            always_comb begin
                cntNext = cntReg;
                isoBit  = isolatedReg[gi];
                if (bus.CLR_FAULT) begin
                    cntNext = '0;
                    isoBit  = 1'b0;
                end else if (bus.IN_VALID && quorum && !isolatedReg[gi]) begin
                    if (disagreeVec[gi]) begin
                        if (cntReg < LIMIT) begin
                            cntNext = cntReg + CW'(1);
                        end
                        if (cntNext == LIMIT) begin
                            isoBit = 1'b1;
                        end
                    end else begin
                        cntNext = '0;
                    end
                end
            end

            // Consecutive-disagreement counter register
            always_ff @(posedge CLK) begin
                if (RST) begin
                    cntReg <= '0;
                end else begin
                    cntReg <= cntNext;
                end
            end

            assign isolatedNext[gi] = isoBit;
        end
    endgenerate

    // Output registers: vote results only move on valid samples; with no
    // active channel the previous word is kept and NO_QUORUM is flagged
    always_ff @(posedge CLK) begin
        if (RST) begin
            fReg        <= '0;
            fValidReg   <= 1'b0;
            disagreeReg <= '0;
            isolatedReg <= '0;
            tieReg      <= 1'b0;
            noQuorumReg <= 1'b0;
        end else begin
            fValidReg   <= bus.IN_VALID;
            isolatedReg <= isolatedNext;
            if (bus.IN_VALID) begin
                if (quorum) begin
                    fReg        <= voteWord;
                    disagreeReg <= disagreeVec;
                    tieReg      <= |tieBits;
                    noQuorumReg <= 1'b0;
                end else begin
                    disagreeReg <= '0;
                    tieReg      <= 1'b0;
                    noQuorumReg <= 1'b1;
                end
            end
        end
    end

    assign bus.F         = fReg;
    assign bus.F_VALID   = fValidReg;
    assign bus.DISAGREE  = disagreeReg;
    assign bus.ISOLATED  = isolatedReg;
    assign bus.TIE       = tieReg;
    assign bus.NO_QUORUM = noQuorumReg;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Bench for majority_voter_seq: two instances (N=3,W=1,limit 4 and
// N=3,W=4,limit 1) driven with directed vectors, checked every cycle against
// an arithmetic reference model, plus hand-computed literal expectations.
module tb_majority_voter_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    majority_voter_seq_if #(.N(3), .W(1)) busA ();
    majority_voter_seq_if #(.N(3), .W(4)) busB ();

    majority_voter_seq #(.N(3), .W(1), .FAULT_LIMIT(4)) dutA (
        .CLK(clk), .RST(rst), .bus(busA)
    );
    majority_voter_seq #(.N(3), .W(4), .FAULT_LIMIT(1)) dutB (
        .CLK(clk), .RST(rst), .bus(busB)
    );

    int compared   = 0;
    int mismatched = 0;
    bit cmpEn      = 1'b0;

    // Reference model state, index 0 = instance A, 1 = instance B
    logic [3:0] mF   [2];
    logic       mFv  [2];
    logic [2:0] mDis [2];
    logic [2:0] mIso [2];
    logic       mTie [2];
    logic       mNoq [2];
    int         mCnt [2][3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the voter, computed from the rules with integers
    task automatic modelStep(input int d, input int w, input int lim, input logic r,
                             input logic v, input logic c, input logic [11:0] data);
        int act;
        int ones;
        logic [3:0] word;
        logic [3:0] chw;
        logic [2:0] newIso;
        logic tieSeen;
        if (r) begin
            mF[d] = '0; mFv[d] = 1'b0; mDis[d] = '0; mIso[d] = '0;
            mTie[d] = 1'b0; mNoq[d] = 1'b0;
            for (int k = 0; k < 3; k++) mCnt[d][k] = 0;
        end else begin
            mFv[d] = v;
            newIso = mIso[d];
            if (v) begin
                act = 0;
                for (int ch = 0; ch < 3; ch++) if (!mIso[d][ch]) act++;
                if (act == 0) begin
                    mNoq[d] = 1'b1; mDis[d] = '0; mTie[d] = 1'b0;
                end else begin
                    word = '0; tieSeen = 1'b0;
                    for (int b = 0; b < w; b++) begin
                        ones = 0;
                        for (int ch = 0; ch < 3; ch++)
                            if (!mIso[d][ch] && data[ch*w + b]) ones++;
                        if (2*ones > act) word[b] = 1'b1;
                        else if (2*ones == act) tieSeen = 1'b1;
                    end
                    mF[d] = word; mTie[d] = tieSeen; mNoq[d] = 1'b0;
                    for (int ch = 0; ch < 3; ch++) begin
                        chw = 4'((data >> (ch*w)) & ((12'd1 << w) - 12'd1));
                        mDis[d][ch] = (chw != word);
                        if (!mIso[d][ch]) begin
                            if (mDis[d][ch]) begin
                                if (mCnt[d][ch] < lim) mCnt[d][ch]++;
                                if (mCnt[d][ch] == lim) newIso[ch] = 1'b1;
                            end else begin
                                mCnt[d][ch] = 0;
                            end
                        end
                    end
                end
            end
            mIso[d] = newIso;
            if (c) begin
                mIso[d] = '0;
                for (int k = 0; k < 3; k++) mCnt[d][k] = 0;
            end
        end
    endtask

    // Advance the model on every rising edge with the inputs the DUTs see
    always @(posedge clk) begin
        modelStep(0, 1, 4, rst, busA.IN_VALID, busA.CLR_FAULT, {9'b0, busA.IN_DATA});
        modelStep(1, 4, 1, rst, busB.IN_VALID, busB.CLR_FAULT, busB.IN_DATA);
    end

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        if (cmpEn) begin
            chk("A.F",         32'(busA.F),         32'(mF[0][0]));
            chk("A.F_VALID",   32'(busA.F_VALID),   32'(mFv[0]));
            chk("A.DISAGREE",  32'(busA.DISAGREE),  32'(mDis[0]));
            chk("A.ISOLATED",  32'(busA.ISOLATED),  32'(mIso[0]));
            chk("A.TIE",       32'(busA.TIE),       32'(mTie[0]));
            chk("A.NO_QUORUM", 32'(busA.NO_QUORUM), 32'(mNoq[0]));
            chk("B.F",         32'(busB.F),         32'(mF[1]));
            chk("B.F_VALID",   32'(busB.F_VALID),   32'(mFv[1]));
            chk("B.DISAGREE",  32'(busB.DISAGREE),  32'(mDis[1]));
            chk("B.ISOLATED",  32'(busB.ISOLATED),  32'(mIso[1]));
            chk("B.TIE",       32'(busB.TIE),       32'(mTie[1]));
            chk("B.NO_QUORUM", 32'(busB.NO_QUORUM), 32'(mNoq[1]));
        end
    end

    // One transaction on instance A (B idle), one edge, report
    task automatic driveA(input logic r, input logic v, input logic c, input logic [2:0] d);
        rst = r;
        busA.IN_VALID = v; busA.CLR_FAULT = c; busA.IN_DATA = d;
        busB.IN_VALID = 1'b0; busB.CLR_FAULT = 1'b0; busB.IN_DATA = '0;
        @(negedge clk);
        $display("A rst=%b v=%b clr=%b d=%b -> F=%b FV=%b DIS=%b ISO=%b TIE=%b NQ=%b",
                 r, v, c, d, busA.F, busA.F_VALID, busA.DISAGREE, busA.ISOLATED,
                 busA.TIE, busA.NO_QUORUM);
    endtask

    // One transaction on instance B (A idle), one edge, report
    task automatic driveB(input logic r, input logic v, input logic c, input logic [11:0] d);
        rst = r;
        busB.IN_VALID = v; busB.CLR_FAULT = c; busB.IN_DATA = d;
        busA.IN_VALID = 1'b0; busA.CLR_FAULT = 1'b0; busA.IN_DATA = '0;
        @(negedge clk);
        $display("B rst=%b v=%b clr=%b d=%h -> F=%h FV=%b DIS=%b ISO=%b TIE=%b NQ=%b",
                 r, v, c, d, busB.F, busB.F_VALID, busB.DISAGREE, busB.ISOLATED,
                 busB.TIE, busB.NO_QUORUM);
    endtask

    logic [7:0] ttExp;

    initial begin
        ttExp = 8'b1110_1000;

        // Reset state
        driveA(1'b1, 1'b0, 1'b0, 3'b000);
        driveA(1'b1, 1'b0, 1'b0, 3'b000);
        cmpEn = 1'b1;
        chk("rst.A.F",        32'(busA.F),        32'd0);
        chk("rst.A.F_VALID",  32'(busA.F_VALID),  32'd0);
        chk("rst.A.ISOLATED", 32'(busA.ISOLATED), 32'd0);
        chk("rst.B.F",        32'(busB.F),        32'd0);

        // Truth table of the 3-input majority gate
        for (int i = 0; i < 8; i++) begin
            driveA(1'b0, 1'b1, 1'b0, 3'(i));
            chk("tt.F",       32'(busA.F),       32'(ttExp[i]));
            chk("tt.F_VALID", 32'(busA.F_VALID), 32'd1);
        end
        driveA(1'b0, 1'b0, 1'b0, 3'b000);
        chk("idle.F_VALID", 32'(busA.F_VALID), 32'd0);
        chk("idle.F_hold",  32'(busA.F),       32'd1);

        // Channel 2 persistently wrong: isolated on the 4th sample
        for (int k = 1; k <= 5; k++) begin
            driveA(1'b0, 1'b1, 1'b0, 3'b100);
            chk("iso.DIS", 32'(busA.DISAGREE), 32'b100);
            chk("iso.F",   32'(busA.F),        32'd0);
            if (k == 3) chk("iso.after3", 32'(busA.ISOLATED), 32'b000);
            if (k >= 4) chk("iso.after4", 32'(busA.ISOLATED), 32'b100);
        end

        // Two active channels: split resolves to 0 with TIE
        driveA(1'b0, 1'b1, 1'b0, 3'b001);
        chk("tie.F",   32'(busA.F),        32'd0);
        chk("tie.TIE", 32'(busA.TIE),      32'd1);
        chk("tie.DIS", 32'(busA.DISAGREE), 32'b001);
        driveA(1'b0, 1'b1, 1'b0, 3'b011);
        chk("agree.F",   32'(busA.F),   32'd1);
        chk("agree.TIE", 32'(busA.TIE), 32'd0);

        // Clear without a sample
        driveA(1'b0, 1'b0, 1'b1, 3'b000);
        chk("clr.ISO", 32'(busA.ISOLATED), 32'b000);

        // Disagreements across bubbles, broken by one agreement
        for (int k = 0; k < 3; k++) begin
            driveA(1'b0, 1'b1, 1'b0, 3'b010);
            driveA(1'b0, 1'b0, 1'b0, 3'b111);
            chk("gap.F_VALID", 32'(busA.F_VALID), 32'd0);
            chk("gap.F",       32'(busA.F),       32'd0);
            chk("gap.DIS",     32'(busA.DISAGREE), 32'b010);
        end
        driveA(1'b0, 1'b1, 1'b0, 3'b000);
        for (int k = 0; k < 3; k++) driveA(1'b0, 1'b1, 1'b0, 3'b010);
        chk("gap.noIso", 32'(busA.ISOLATED), 32'b000);

        // Reset mid-stream: isolate ch0, bring ch1 counter to 2, then reset
        driveA(1'b0, 1'b0, 1'b1, 3'b000);
        for (int k = 0; k < 4; k++) driveA(1'b0, 1'b1, 1'b0, 3'b001);
        chk("pre.ISO", 32'(busA.ISOLATED), 32'b001);
        driveA(1'b0, 1'b1, 1'b0, 3'b010);
        driveA(1'b0, 1'b1, 1'b0, 3'b010);
        driveA(1'b1, 1'b1, 1'b0, 3'b010);
        chk("mrst.F",   32'(busA.F),         32'd0);
        chk("mrst.FV",  32'(busA.F_VALID),   32'd0);
        chk("mrst.DIS", 32'(busA.DISAGREE),  32'd0);
        chk("mrst.ISO", 32'(busA.ISOLATED),  32'd0);
        chk("mrst.TIE", 32'(busA.TIE),       32'd0);
        chk("mrst.NQ",  32'(busA.NO_QUORUM), 32'd0);
        for (int k = 0; k < 3; k++) driveA(1'b0, 1'b1, 1'b0, 3'b010);
        chk("post.ISO", 32'(busA.ISOLATED), 32'b000);
        driveA(1'b0, 1'b1, 1'b0, 3'b011);
        chk("post.F",   32'(busA.F),   32'd1);
        chk("post.TIE", 32'(busA.TIE), 32'd0);

        // W=4, limit 1: every channel off the vote, then no quorum and clear
        driveB(1'b0, 1'b1, 1'b0, 12'hFFF);
        chk("B.allF", 32'(busB.F), 32'hF);
        driveB(1'b0, 1'b1, 1'b0, {4'b1011, 4'b1101, 4'b1110});
        chk("B.splitF",   32'(busB.F),        32'hF);
        chk("B.splitDIS", 32'(busB.DISAGREE), 32'b111);
        chk("B.splitISO", 32'(busB.ISOLATED), 32'b111);
        driveB(1'b0, 1'b1, 1'b0, 12'h000);
        chk("B.nq",     32'(busB.NO_QUORUM), 32'd1);
        chk("B.nqF",    32'(busB.F),         32'hF);
        chk("B.nqFV",   32'(busB.F_VALID),   32'd1);
        chk("B.nqDIS",  32'(busB.DISAGREE),  32'd0);
        driveB(1'b0, 1'b0, 1'b0, 12'h000);
        chk("B.idleNQ", 32'(busB.NO_QUORUM), 32'd1);
        driveB(1'b0, 1'b1, 1'b1, 12'h000);
        chk("B.clrNQ",  32'(busB.NO_QUORUM), 32'd1);
        chk("B.clrF",   32'(busB.F),         32'hF);
        chk("B.clrISO", 32'(busB.ISOLATED),  32'b000);
        driveB(1'b0, 1'b1, 1'b0, 12'h000);
        chk("B.backF",   32'(busB.F),         32'h0);
        chk("B.backNQ",  32'(busB.NO_QUORUM), 32'd0);
        chk("B.backISO", 32'(busB.ISOLATED),  32'b000);
        driveB(1'b0, 1'b1, 1'b0, 12'h00F);
        chk("B.oneF",   32'(busB.F),        32'h0);
        chk("B.oneISO", 32'(busB.ISOLATED), 32'b001);

        driveB(1'b0, 1'b0, 1'b0, 12'h000);
        cmpEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
